spike_aer_encoder: RTL

- Downstream of the LIF neuron array. Collects the per-neuron `spike_out` pulses (NUM_NEURONS wide) and serialises them into Address-Event Representation (AER) events.
- Events leave on a valid/ready stream consumed by the spike router / output DMA.
- Round-robin arbitration, a pending-spike latch and an event FIFO absorb bursts without losing coincident spikes.

---
 rtl/spike_aer_encoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spike_aer_encoder.sv
// ---------------------------------------------------------------------------
// spike_aer_encoder
//
// Purpose:
//    Collects one-cycle spike pulses from the LIF neuron array and serialises
//    them into Address-Event Representation (AER) events on a valid/ready
//    stream. A pending-spike latch remembers every neuron that fired. A
//    round-robin arbiter moves one pending neuron per cycle into a
//    first-word-fall-through event FIFO. Coincident spikes are therefore not
//    lost while the consumer stalls.
//
// Ports:
//    clk          clock
//    rst_n        synchronous, active-low reset
//    enable       capture/arbitration enable (the output side drains regardless)
//    spike_in     one-cycle spike pulses, bit i is neuron i
//    time_tick    advances the timestep counter
//    m_valid      head event available
//    m_ready      consumer accepts the head event
//    m_neuron_id  neuron ID of the head event
//    m_timestamp  timestep of the head event (0 when timestamps are disabled)
//    fifo_count   event FIFO occupancy
//    pending_any  OR of the pending latch
//    drop_count   saturating count of cycles in which spikes merged (were lost)
//
// Build option:
//    AER_TIMESTAMP_EN  when defined, a timestep counter and a per-entry
//                      timestamp field are built and m_timestamp reports the
//                      timestep in which each event was granted. When it is
//                      undefined, m_timestamp is tied to 0 and time_tick is
//                      ignored.
// ---------------------------------------------------------------------------
module spike_aer_encoder #(
   parameter int NUM_NEURONS = 16,
   parameter int ID_WIDTH    = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int TS_WIDTH    = 16,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [NUM_NEURONS-1:0]        spike_in,
   input  logic                          time_tick,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [ID_WIDTH-1:0]           m_neuron_id,
   output logic [TS_WIDTH-1:0]           m_timestamp,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          pending_any,
   output logic [CNT_WIDTH-1:0]          drop_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [ID_WIDTH:0]   NUM_LIMIT  = (ID_WIDTH+1)'(NUM_NEURONS);
   localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(NUM_NEURONS - 1);

   logic [NUM_NEURONS-1:0] r_pend;
   logic [ID_WIDTH-1:0]    r_rrPtr;
   logic [CNT_WIDTH-1:0]   r_dropCount;

   logic [PTR_W-1:0]       r_wrPtr;
   logic [PTR_W-1:0]       r_rdPtr;
   logic [CNT_W-1:0]       r_count;
   logic [ID_WIDTH-1:0]    r_idMem [FIFO_DEPTH];

   logic                   w_grantValid;
   logic [ID_WIDTH-1:0]    w_grantId;
   logic [NUM_NEURONS-1:0] w_grantVec;
   logic [ID_WIDTH:0]      w_candidate;
   logic [ID_WIDTH-1:0]    w_rrNext;
   logic                   w_collision;
   logic                   w_push;
   logic                   w_pop;

   // Round-robin arbiter. The scan visits offsets from rr_ptr downward, so
   // the last hit written is the set bit closest to rr_ptr (smallest
   // (i - rr_ptr) mod N). The full check uses the registered count: a pop in
   // the same cycle does not make room for this push.
   always_comb begin
      w_grantValid = 1'b0;
      w_grantId    = '0;
      w_grantVec   = '0;
      w_candidate  = '0;
      if (enable && (r_pend != '0) && (r_count < FULL_COUNT)) begin
         w_grantValid = 1'b1;
         for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
            w_candidate = {1'b0, r_rrPtr} + (ID_WIDTH+1)'(k);
            if (w_candidate >= NUM_LIMIT) begin
               w_candidate = w_candidate - NUM_LIMIT;
            end
            if (r_pend[w_candidate[ID_WIDTH-1:0]]) begin
               w_grantId = w_candidate[ID_WIDTH-1:0];
            end
         end
         w_grantVec[w_grantId] = 1'b1;
      end
   end

   // The pointer moves to just past the winner so that it ranks last next time.
   assign w_rrNext = (w_grantId == LAST_ID) ? '0 : (w_grantId + ID_WIDTH'(1));

   // A collision is a new spike landing on a neuron that is still pending and
   // is not being granted in this cycle. The two spikes merge, so one is lost.
   assign w_collision = enable && ((spike_in & r_pend & ~w_grantVec) != '0);

   assign w_push  = w_grantValid;
   assign w_pop   = m_valid && m_ready;

   // Pending latch, arbitration pointer and drop counter. When enable is low,
   // the latch freezes and incoming spikes are ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend      <= '0;
         r_rrPtr     <= '0;
         r_dropCount <= '0;
      end else begin
         if (enable) begin
            r_pend <= (r_pend & ~w_grantVec) | spike_in;
         end
         if (w_grantValid) begin
            r_rrPtr <= w_rrNext;
         end
         if (w_collision && (r_dropCount != '1)) begin
            r_dropCount <= r_dropCount + CNT_WIDTH'(1);
         end
      end
   end

   // FIFO pointers and occupancy. The pointers wrap naturally because
   // FIFO_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Event storage. There is no reset because the outputs are gated by m_valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_idMem[r_wrPtr] <= w_grantId;
      end
   end

`ifdef AER_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] r_tsCounter;
   logic [TS_WIDTH-1:0] r_tsMem [FIFO_DEPTH];

   // The timestep counter runs independently of enable and wraps at 2^TS_WIDTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tsCounter <= '0;
      end else if (time_tick) begin
         r_tsCounter <= r_tsCounter + TS_WIDTH'(1);
      end
   end

   // The timestamp is captured alongside the ID in the grant cycle.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tsMem[r_wrPtr] <= r_tsCounter;
      end
   end

   assign m_timestamp = m_valid ? r_tsMem[r_rdPtr] : '0;
`else
   logic w_unusedTick;
   assign w_unusedTick = time_tick;
   assign m_timestamp  = '0;
`endif

   assign m_valid     = (r_count != '0);
   assign m_neuron_id = m_valid ? r_idMem[r_rdPtr] : '0;
   assign fifo_count  = r_count;
   assign pending_any = |r_pend;
   assign drop_count  = r_dropCount;

endmodule
